// File: rtl/map_table_ckpt_pkg.sv
// Shared types and default sizing for the checkpointed register map table.
// The restore engine walks the table in lane groups; lane_count gives the number of groups.
package map_table_ckpt_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RESTORE = 1'b1
  } state_t;

  localparam int DEF_SRAM_DEPTH    = 32;
  localparam int DEF_SRAM_INDEX    = 5;
  localparam int DEF_SRAM_WIDTH    = 7;
  localparam int DEF_RD_PORTS      = 4;
  localparam int DEF_WR_PORTS      = 4;
  localparam int DEF_NUM_CKPT      = 4;
  localparam int DEF_CKPT_INDEX    = 2;
  localparam int DEF_RESTORE_LANES = 8;
  localparam int DEF_BYPASS        = 0;

  function automatic int lane_count(input int depth, input int lanes);
    return depth / lanes;
  endfunction

endpackage

// File: rtl/map_ckpt_store.sv
// Snapshot storage: NUM_CKPT full copies of the map table, written whole in one cycle
// and read back one lane group at a time through a registered read port.
module map_ckpt_store #(
  parameter int SRAM_DEPTH    = 32,
  parameter int SRAM_INDEX    = 5,
  parameter int SRAM_WIDTH    = 7,
  parameter int NUM_CKPT      = 4,
  parameter int CKPT_INDEX    = 2,
  parameter int RESTORE_LANES = 8,
  parameter int CNT_W         = 2
) (
  input  logic                             clk,
  input  logic                             wr_en,
  input  logic [CKPT_INDEX-1:0]            wr_id,
  input  logic [SRAM_DEPTH*SRAM_WIDTH-1:0] wr_data,
  input  logic [CKPT_INDEX-1:0]            rd_id,
  input  logic [CNT_W-1:0]                 rd_lane,
  output logic [RESTORE_LANES*SRAM_WIDTH-1:0] rd_data
);

  logic [SRAM_WIDTH-1:0] mem [NUM_CKPT][SRAM_DEPTH];
  logic [SRAM_INDEX-1:0] rd_base;

  assign rd_base = SRAM_INDEX'(rd_lane) * SRAM_INDEX'(RESTORE_LANES);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < SRAM_DEPTH; i++) begin
        mem[wr_id][i] <= wr_data[i*SRAM_WIDTH +: SRAM_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < RESTORE_LANES; l++) begin
      rd_data[l*SRAM_WIDTH +: SRAM_WIDTH] <= mem[rd_id][rd_base + SRAM_INDEX'(l)];
    end
  end

endmodule

// File: rtl/map_table_ckpt.sv
// Multi-port register map table with full-table checkpoints and a lane-by-lane restore engine.
// The lane read is prefetched one cycle ahead so each busy cycle copies one lane group.
module map_table_ckpt
  import map_table_ckpt_pkg::*;
#(
  parameter int SRAM_DEPTH    = DEF_SRAM_DEPTH,
  parameter int SRAM_INDEX    = DEF_SRAM_INDEX,
  parameter int SRAM_WIDTH    = DEF_SRAM_WIDTH,
  parameter int RD_PORTS      = DEF_RD_PORTS,
  parameter int WR_PORTS      = DEF_WR_PORTS,
  parameter int NUM_CKPT      = DEF_NUM_CKPT,
  parameter int CKPT_INDEX    = DEF_CKPT_INDEX,
  parameter int RESTORE_LANES = DEF_RESTORE_LANES,
  parameter int BYPASS        = DEF_BYPASS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [RD_PORTS*SRAM_INDEX-1:0] rd_addr_i,
  output logic [RD_PORTS*SRAM_WIDTH-1:0] rd_data_o,
  input  logic [WR_PORTS-1:0]            wr_en_i,
  input  logic [WR_PORTS*SRAM_INDEX-1:0] wr_addr_i,
  input  logic [WR_PORTS*SRAM_WIDTH-1:0] wr_data_i,
  input  logic                           ckpt_we_i,
  input  logic [CKPT_INDEX-1:0]          ckpt_id_i,
  input  logic                           ckpt_free_i,
  input  logic [CKPT_INDEX-1:0]          free_id_i,
  input  logic                           restore_i,
  input  logic [CKPT_INDEX-1:0]          restore_id_i,
  output logic                           busy_o,
  output logic                           restore_done_o,
  output logic                           restore_err_o,
  output logic [NUM_CKPT-1:0]            ckpt_valid_o
);

  localparam int LANE_CNT = lane_count(SRAM_DEPTH, RESTORE_LANES);
  localparam int CNT_W    = (LANE_CNT > 1) ? $clog2(LANE_CNT) : 1;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [CKPT_INDEX-1:0] slot_reg, slot_next;
  logic [NUM_CKPT-1:0]   valid_reg, valid_next;
  logic [SRAM_WIDTH-1:0] table_reg [SRAM_DEPTH];
  logic [SRAM_WIDTH-1:0] table_next [SRAM_DEPTH];

  logic idle, restore_ok, write_ok, ckpt_ok, last_lane;
  logic [SRAM_INDEX-1:0]                  restore_base;
  logic [SRAM_DEPTH*SRAM_WIDTH-1:0]       snap_data;
  logic [RESTORE_LANES*SRAM_WIDTH-1:0]    lane_data;
  logic [CKPT_INDEX-1:0]                  store_rd_id;
  logic [CNT_W-1:0]                       store_rd_lane;

  assign idle         = (state_reg == IDLE);
  assign restore_ok   = idle && restore_i && valid_reg[restore_id_i];
  assign write_ok     = idle && !restore_i;
  assign ckpt_ok      = write_ok && ckpt_we_i;
  assign last_lane    = (cnt_reg == CNT_W'(LANE_CNT - 1));
  assign restore_base = SRAM_INDEX'(cnt_reg) * SRAM_INDEX'(RESTORE_LANES);

  // In IDLE the store is pointed at lane 0 of the requested slot so it is ready on the first busy cycle.
  assign store_rd_id   = idle ? restore_id_i : slot_reg;
  assign store_rd_lane = idle ? '0 : cnt_reg + CNT_W'(1);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    slot_next  = slot_reg;
    case (state_reg)
      IDLE: begin
        if (restore_ok) begin
          state_next = RESTORE;
          cnt_next   = '0;
          slot_next  = restore_id_i;
        end
      end
      RESTORE: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (last_lane) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    table_next = table_reg;
    if (state_reg == RESTORE) begin
      for (int l = 0; l < RESTORE_LANES; l++) begin
        table_next[restore_base + SRAM_INDEX'(l)] = lane_data[l*SRAM_WIDTH +: SRAM_WIDTH];
      end
    end else if (write_ok) begin
      for (int w = 0; w < WR_PORTS; w++) begin
        if (wr_en_i[w]) table_next[wr_addr_i[w*SRAM_INDEX +: SRAM_INDEX]] = wr_data_i[w*SRAM_WIDTH +: SRAM_WIDTH];
      end
    end
  end

  // Set is applied after free so a same-slot take/release keeps the slot valid.
  always_comb begin
    valid_next = valid_reg;
    if (ckpt_free_i) valid_next[free_id_i] = 1'b0;
    if (ckpt_ok)     valid_next[ckpt_id_i] = 1'b1;
  end

  generate
    for (genvar gi = 0; gi < SRAM_DEPTH; gi++) begin : g_snap
      assign snap_data[gi*SRAM_WIDTH +: SRAM_WIDTH] = table_next[gi];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd
      logic [SRAM_INDEX-1:0] addr;
      logic [SRAM_WIDTH-1:0] rd_val;
      assign addr = rd_addr_i[gi*SRAM_INDEX +: SRAM_INDEX];
      always_comb begin
        rd_val = table_reg[addr];
        if (BYPASS != 0) begin
          for (int w = 0; w < WR_PORTS; w++) begin
            if (write_ok && wr_en_i[w] && (wr_addr_i[w*SRAM_INDEX +: SRAM_INDEX] == addr))
              rd_val = wr_data_i[w*SRAM_WIDTH +: SRAM_WIDTH];
          end
        end
      end
      assign rd_data_o[gi*SRAM_WIDTH +: SRAM_WIDTH] = rd_val;
    end
  endgenerate

  map_ckpt_store #(
    .SRAM_DEPTH    (SRAM_DEPTH),
    .SRAM_INDEX    (SRAM_INDEX),
    .SRAM_WIDTH    (SRAM_WIDTH),
    .NUM_CKPT      (NUM_CKPT),
    .CKPT_INDEX    (CKPT_INDEX),
    .RESTORE_LANES (RESTORE_LANES),
    .CNT_W         (CNT_W)
  ) u_store (
    .clk     (clk),
    .wr_en   (ckpt_ok),
    .wr_id   (ckpt_id_i),
    .wr_data (snap_data),
    .rd_id   (store_rd_id),
    .rd_lane (store_rd_lane),
    .rd_data (lane_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      slot_reg  <= '0;
      valid_reg <= '0;
      for (int i = 0; i < SRAM_DEPTH; i++) table_reg[i] <= SRAM_WIDTH'(i);
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      slot_reg  <= slot_next;
      valid_reg <= valid_next;
      table_reg <= table_next;
    end
  end

  assign busy_o         = (state_reg == RESTORE);
  assign restore_done_o = (state_reg == RESTORE) && last_lane;
  assign restore_err_o  = !reset && idle && restore_i && !valid_reg[restore_id_i];
  assign ckpt_valid_o   = valid_reg;

endmodule

// File: doc/map_table_ckpt.md
Name: map_table_ckpt

Overview:
Parametrised multi-port register map table with NUM_CKPT full-table checkpoints and a multi-cycle restore engine. It serves as the rename/architectural map for wider core configurations. Branches snapshot the table, and mispredict recovery copies a snapshot back into the live table RESTORE_LANES entries per cycle. Port count, width and depth are all parameters.

Parameters:
SRAM_DEPTH, 32, number of logical-register entries; power of 2
SRAM_INDEX, 5, log2(SRAM_DEPTH)
SRAM_WIDTH, 7, bits per entry (physical tag); must be >= SRAM_INDEX
RD_PORTS, 4, combinational read ports
WR_PORTS, 4, write ports
NUM_CKPT, 4, checkpoint slots
CKPT_INDEX, 2, log2(NUM_CKPT)
RESTORE_LANES, 8, entries copied per restore cycle; must divide SRAM_DEPTH
BYPASS, 0, 1 = read ports see same-cycle write data

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
rd_addr_i  in  RD_PORTS*SRAM_INDEX  packed read addresses; port p at [p*SRAM_INDEX +: SRAM_INDEX]
rd_data_o  out  RD_PORTS*SRAM_WIDTH  packed read data
wr_en_i  in  WR_PORTS  per-port write enable
wr_addr_i  in  WR_PORTS*SRAM_INDEX  packed write addresses
wr_data_i  in  WR_PORTS*SRAM_WIDTH  packed write data
ckpt_we_i  in  1  take a snapshot into slot ckpt_id_i
ckpt_id_i  in  CKPT_INDEX  snapshot target slot
ckpt_free_i  in  1  invalidate slot free_id_i
free_id_i  in  CKPT_INDEX  slot to release
restore_i  in  1  start restore from slot restore_id_i
restore_id_i  in  CKPT_INDEX  restore source slot
busy_o  out  1  restore in progress
restore_done_o  out  1  one-cycle pulse on the final restore copy cycle
restore_err_o  out  1  one-cycle pulse when a restore is requested from an invalid slot
ckpt_valid_o  out  NUM_CKPT  per-slot valid bits

Behaviour:
- Reset (synchronous): live entry i <= i (identity map); all ckpt valid bits 0; FSM to IDLE; busy_o=0, restore_done_o=0, restore_err_o=0. Checkpoint data is not cleared. Reset during RESTORE aborts the restore; the table is identity on the next cycle.
- Reads: combinational from the live table.
  - BYPASS=1: if any enabled write port targets the read address this cycle, return that port's data (highest write port wins).
  - BYPASS=0: return the registered value.
- Writes: take effect at posedge when wr_en_i[w]=1. If several ports hit the same address, the highest-index port wins.
- Checkpoint: on ckpt_we_i in IDLE, slot ckpt_id_i <= next-state of the table, i.e. it includes this cycle's writes. Valid bit is set.
  - ckpt_we_i and ckpt_free_i on the same slot: the set wins.
  - Overwriting a valid slot is legal.
- Free: clears the valid bit at posedge.
- FSM states:
  - IDLE --restore_i with valid slot--> RESTORE. Latch the slot id, clear the lane counter, assert busy_o from the next cycle.
  - IDLE --restore_i with invalid slot--> IDLE, restore_err_o=1 for 1 cycle.
  - RESTORE: each cycle copy entries [cnt*RESTORE_LANES +: RESTORE_LANES] from the latched slot into the live table, then cnt++.
  - On the cycle with cnt = SRAM_DEPTH/RESTORE_LANES-1: restore_done_o=1, next state IDLE.
  - Total latency is SRAM_DEPTH/RESTORE_LANES cycles of busy_o (4 with defaults). The first busy cycle already writes lane 0.
- Same-cycle priority with restore_i in IDLE: restore wins; writes and ckpt_we_i in that cycle are dropped. ckpt_free_i is still honoured.
- While busy_o=1: writes, ckpt_we_i and restore_i are ignored; ckpt_free_i is honoured. A freed slot that is currently being restored still completes the copy.
- Reads during RESTORE return the live table, which is partially restored. Consumers must stall on busy_o.
- The restored slot stays valid after the restore.

Decomposition:
- Shared package: FSM state enum {IDLE, RESTORE}; default parameter constants; the lane-count function SRAM_DEPTH/RESTORE_LANES.
- Sub-module map_ckpt_store: NUM_CKPT x SRAM_DEPTH snapshot array with a full-width write port and a RESTORE_LANES-wide lane read port.
- The FSM, port priority and bypass logic stay in the top level.

Test Plan:
- Reset, then read all 32 entries -> entry i == i; ckpt_valid_o=0000; busy_o=0.
- Write ports 0 and 3 both target addr 5 with data 0x11/0x33 -> next cycle addr 5 reads 0x33. With BYPASS=1 a same-cycle read of 5 returns 0x33.
- Write addr 2=0x40 in the same cycle as ckpt_we_i id=1 -> slot 1 valid and holds 0x40. Later write addr 2=0x55, then restore id=1 -> busy_o high exactly 4 cycles, restore_done_o on the 4th, then addr 2 reads 0x40.
- restore_i id=2 while slot 2 invalid -> restore_err_o pulse, busy_o stays 0, table unchanged.
- During RESTORE assert wr_en_i, ckpt_we_i and a second restore_i -> all ignored, and the final table equals the snapshot. ckpt_free_i id=0 in the same window -> ckpt_valid_o[0] clears.
- Assert reset in the 2nd restore cycle -> next cycle identity table, busy_o=0, no restore_done_o pulse, ckpt_valid_o=0.
